// File: rtl/pt_hex_scroller.sv
// pt_hex_scroller: after key search completes, reads the length-prefixed
// plaintext memory and scrolls it as hex bytes across six 7-segment digits,
// three bytes per window, advancing one byte per window.
// Optional build macro: PT_SCROLL_PAUSE_EN adds a `pause` input that freezes
// the window timer while in SHOW.
module pt_hex_scroller #(
    parameter int unsigned TICKS  = 25000000,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic              key_valid,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [7:0]        pt_rddata,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
`ifdef PT_SCROLL_PAUSE_EN
    ,
    input  logic              pause
`endif
);

    localparam int unsigned TW  = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam int unsigned IW  = ADDR_W + 1;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'h3F;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LEN = 3'd1,
        WT_LEN = 3'd2,
        FETCH  = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [ADDR_W-1:0] p;
    logic [7:0]        len;
    logic [1:0]        fk;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic              bl0;
    logic              bl1;
    logic [41:0]       disp;

    logic              pause_c;
    logic [IW-1:0]     next_idx_c;
    logic [IW-1:0]     cap_idx_c;
    logic              next_blank_c;
    logic              cap_blank_c;
    logic              last_c;

`ifdef PT_SCROLL_PAUSE_EN
    assign pause_c = pause;
`else
    assign pause_c = 1'b0;
`endif

    // Active-low gfedcba encoding of one hex nibble
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Two digits for one byte; blank bytes dark on both digits
    function automatic logic [13:0] byte_segs(input logic [7:0] b, input logic blank);
        logic [13:0] s;
        if (blank) s = {SEG_BLANK, SEG_BLANK};
        else       s = {seg7(b[7:4]), seg7(b[3:0])};
        return s;
    endfunction

    // Window index arithmetic: one extra bit so a wrap past the address space reads as beyond L
    always_comb begin
        next_idx_c   = {1'b0, p} + IW'(fk) + IW'(1);
        cap_idx_c    = {1'b0, p} + IW'(fk) - IW'(1);
        next_blank_c = next_idx_c[ADDR_W] || (32'(next_idx_c) > 32'(len));
        cap_blank_c  = cap_idx_c[ADDR_W]  || (32'(cap_idx_c)  > 32'(len));
        last_c       = (32'(p) == 32'(len));
    end

    // Control FSM with registered handshake, address and display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy     <= 1'b1;
            pt_addr <= '0;
            timer   <= '0;
            p       <= ADDR_W'(1);
            len     <= '0;
            fk      <= '0;
            b0      <= '0;
            b1      <= '0;
            bl0     <= 1'b1;
            bl1     <= 1'b1;
            disp    <= {6{SEG_BLANK}};
        end else begin
            case (state)
                IDLE: begin
                    if (en && rdy) begin
                        rdy <= 1'b0;
                        if (key_valid) begin
                            pt_addr <= '0;
                            state   <= RD_LEN;
                        end else begin
                            // no key: show dashes, stay idle, rdy recovers next cycle
                            disp <= {6{SEG_DASH}};
                        end
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                RD_LEN: begin
                    state <= WT_LEN;
                end
                WT_LEN: begin
                    len <= pt_rddata;
                    if (pt_rddata == 8'd0) begin
                        disp  <= {6{SEG_BLANK}};
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        p       <= ADDR_W'(1);
                        pt_addr <= ADDR_W'(1);
                        fk      <= '0;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    fk <= fk + 2'd1;
                    if (fk < 2'd2 && !next_blank_c) pt_addr <= next_idx_c[ADDR_W-1:0];
                    case (fk)
                        2'd1: begin
                            b0  <= pt_rddata;
                            bl0 <= cap_blank_c;
                        end
                        2'd2: begin
                            b1  <= pt_rddata;
                            bl1 <= cap_blank_c;
                        end
                        2'd3: begin
                            disp  <= {byte_segs(b0, bl0), byte_segs(b1, bl1),
                                      byte_segs(pt_rddata, cap_blank_c)};
                            timer <= '0;
                            state <= SHOW;
                        end
                        default: ;
                    endcase
                end
                SHOW: begin
                    if (!pause_c) begin
                        if (timer == TW'(TICKS - 1)) begin
                            timer <= '0;
                            if (last_c) begin
                                rdy   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                p       <= p + ADDR_W'(1);
                                pt_addr <= p + ADDR_W'(1);
                                fk      <= '0;
                                state   <= FETCH;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                default: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {hex5, hex4, hex3, hex2, hex1, hex0} = disp;

endmodule
